// File: rtl/datapath_pkg.sv
// Shared datapath types and sizing for the operand stage and the ALU.
// State and shift-op encodings live here so every datapath block agrees on them.
package datapath_pkg;

  localparam int W     = 16;
  localparam int NREGS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_A  = 2'd1,
    RD_B  = 2'd2,
    VALID = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    SHL   = 2'd1,
    SHR_L = 2'd2,
    SHR_A = 2'd3
  } shift_op_t;

endpackage

// File: rtl/operand_stage_regfile.sv
// NREGS x W register file: one synchronous write port, one combinational read port.
// Reset clears every entry and wins over a write in the same cycle.
module regfile
  import datapath_pkg::*;
#(
  parameter int W     = datapath_pkg::W,
  parameter int NREGS = datapath_pkg::NREGS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write,
  input  logic [$clog2(NREGS)-1:0] writenum,
  input  logic [W-1:0]             data_in,
  input  logic [$clog2(NREGS)-1:0] readnum,
  output logic [W-1:0]             data_out
);

  logic [W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (write) begin
      regs[writenum] <= data_in;
    end
  end

  assign data_out = regs[readnum];

endmodule

// File: rtl/operand_stage.sv
// Operand-fetch stage: reads A then B through a single regfile read port and
// hands registered Ain/Bin to the ALU over valid/ready. Macro: OPERAND_FWD_EN.
//
// state | meaning
// IDLE  | req_ready high; a request latches all fields
// RD_A  | read source A, capture Ain (0 when asel)
// RD_B  | read source B, capture Bin (shifted, or imm5 when bsel)
// VALID | out_valid high; hold Ain/Bin until out_ready
module operand_stage
  import datapath_pkg::*;
#(
  parameter int W     = datapath_pkg::W,
  parameter int NREGS = datapath_pkg::NREGS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write,
  input  logic [$clog2(NREGS)-1:0] writenum,
  input  logic [W-1:0]             data_in,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [$clog2(NREGS)-1:0] readnum_a,
  input  logic [$clog2(NREGS)-1:0] readnum_b,
  input  logic [1:0]               shift,
  input  logic                     asel,
  input  logic                     bsel,
  input  logic [4:0]               imm5,
  output logic [W-1:0]             Ain,
  output logic [W-1:0]             Bin,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int IW = $clog2(NREGS);

  state_t          state, state_nxt;
  logic [IW-1:0]   ra_q, rb_q;
  shift_op_t       shift_q;
  logic            asel_q, bsel_q;
  logic [4:0]      imm5_q;
  logic [IW-1:0]   raddr;
  logic [W-1:0]    rdata, rd_val, b_shifted, imm_ext;
  logic [W-1:0]    a_q, b_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = RD_A;
      RD_A:    state_nxt = RD_B;
      RD_B:    state_nxt = VALID;
      VALID:   if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign out_valid = (state == VALID);

  // Request fields are frozen at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      ra_q    <= '0;
      rb_q    <= '0;
      shift_q <= NONE;
      asel_q  <= 1'b0;
      bsel_q  <= 1'b0;
      imm5_q  <= '0;
    end else if (state == IDLE && req_valid) begin
      ra_q    <= readnum_a;
      rb_q    <= readnum_b;
      shift_q <= shift_op_t'(shift);
      asel_q  <= asel;
      bsel_q  <= bsel;
      imm5_q  <= imm5;
    end
  end

  assign raddr = (state == RD_B) ? rb_q : ra_q;

  regfile #(.W(W), .NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .write    (write),
    .writenum (writenum),
    .data_in  (data_in),
    .readnum  (raddr),
    .data_out (rdata)
  );

`ifdef OPERAND_FWD_EN
  assign rd_val = (write && writenum == raddr) ? data_in : rdata;
`else
  assign rd_val = rdata;
`endif

  always_comb begin
    b_shifted = rd_val;
    case (shift_q)
      SHL:     b_shifted = {rd_val[W-2:0], 1'b0};
      SHR_L:   b_shifted = {1'b0, rd_val[W-1:1]};
      SHR_A:   b_shifted = {rd_val[W-1], rd_val[W-1:1]};
      default: b_shifted = rd_val;
    endcase
  end

  assign imm_ext = {{(W-5){imm5_q[4]}}, imm5_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (state == RD_A) begin
      a_q <= asel_q ? '0 : rd_val;
    end else if (state == RD_B) begin
      b_q <= bsel_q ? imm_ext : b_shifted;
    end
  end

  assign Ain = a_q;
  assign Bin = b_q;

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: vector table, hand-written corner
// sequences, and random requests against a plain-arithmetic reference model.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [2:0]  writenum;
  logic [15:0] data_in;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  readnum_a, readnum_b;
  logic [1:0]  shift;
  logic        asel, bsel;
  logic [4:0]  imm5;
  logic [15:0] Ain, Bin;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;
  int mem [8];

  operand_stage dut (
    .clk(clk), .reset(reset), .write(write), .writenum(writenum),
    .data_in(data_in), .req_valid(req_valid), .req_ready(req_ready),
    .readnum_a(readnum_a), .readnum_b(readnum_b), .shift(shift),
    .asel(asel), .bsel(bsel), .imm5(imm5), .Ain(Ain), .Bin(Bin),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  a, b;
    logic [1:0]  sh;
    logic        as, bs;
    logic [4:0]  im;
    logic [15:0] ea, eb;
  } vec_t;

  vec_t vecs [8];

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  // Reference: B operand from stored value, shift op, select and immediate.
  function automatic logic [15:0] model_b(int v, int sh, int bs, int im);
    if (bs != 0) return (im >= 16) ? 16'(im + 65504) : 16'(im);
    case (sh)
      0:       return 16'(v);
      1:       return 16'((v * 2) % 65536);
      2:       return 16'(v / 2);
      default: return 16'(v / 2 + ((v >= 32768) ? 32768 : 0));
    endcase
  endfunction

  task automatic do_write(input logic [2:0] idx, input logic [15:0] val);
    @(negedge clk);
    write = 1'b1; writenum = idx; data_in = val;
    @(negedge clk);
    write = 1'b0;
    mem[idx] = int'(val);
  endtask

  task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sh,
                       input logic as, input logic bs, input logic [4:0] im,
                       input int hold, input logic fw_wr, input logic [2:0] fw_idx,
                       input logic [15:0] fw_val,
                       output logic [15:0] ga, output logic [15:0] gb);
    int lat;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; readnum_a = a; readnum_b = b; shift = sh;
    asel = as; bsel = bs; imm5 = im;
    @(negedge clk);
    req_valid = 1'b0;
    readnum_a = 3'($urandom); readnum_b = 3'($urandom); shift = 2'($urandom);
    asel = 1'($urandom); bsel = 1'($urandom); imm5 = 5'($urandom);
    if (fw_wr) begin
      write = 1'b1; writenum = fw_idx; data_in = fw_val;
    end
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      write = 1'b0;
      lat++;
    end
    write = 1'b0;
    chk("latency", lat, 3);
    ga = Ain; gb = Bin;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      readnum_a = 3'($urandom); readnum_b = 3'($urandom);
      @(negedge clk);
      chk("hold_ain", {16'd0, Ain}, {16'd0, ga});
      chk("hold_bin", {16'd0, Bin}, {16'd0, gb});
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("xfer_out_valid", {31'd0, out_valid}, 32'd0);
    chk("xfer_req_ready", {31'd0, req_ready}, 32'd1);
    chk("xfer_ain_kept", {16'd0, Ain}, {16'd0, ga});
    chk("xfer_bin_kept", {16'd0, Bin}, {16'd0, gb});
  endtask

  initial begin
    logic [15:0] ga, gb;
    logic [2:0]  ra, rb;
    logic [1:0]  sh;
    logic        as, bs;
    logic [4:0]  im;

    reset = 1'b1; write = 1'b0; writenum = '0; data_in = '0;
    req_valid = 1'b0; readnum_a = '0; readnum_b = '0; shift = '0;
    asel = 1'b0; bsel = 1'b0; imm5 = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 0;

    vecs[0] = '{a:3'd0, b:3'd1, sh:2'b00, as:1'b0, bs:1'b0, im:5'b00000, ea:16'h0000, eb:16'h0005};
    vecs[1] = '{a:3'd0, b:3'd2, sh:2'b11, as:1'b0, bs:1'b0, im:5'b00000, ea:16'h0000, eb:16'hC001};
    vecs[2] = '{a:3'd0, b:3'd2, sh:2'b10, as:1'b0, bs:1'b0, im:5'b00000, ea:16'h0000, eb:16'h4001};
    vecs[3] = '{a:3'd0, b:3'd2, sh:2'b01, as:1'b0, bs:1'b0, im:5'b00000, ea:16'h0000, eb:16'h0006};
    vecs[4] = '{a:3'd1, b:3'd2, sh:2'b11, as:1'b0, bs:1'b1, im:5'b10110, ea:16'h0005, eb:16'hFFF6};
    vecs[5] = '{a:3'd2, b:3'd1, sh:2'b00, as:1'b1, bs:1'b0, im:5'b00000, ea:16'h0000, eb:16'h0005};
    vecs[6] = '{a:3'd2, b:3'd2, sh:2'b00, as:1'b0, bs:1'b0, im:5'b00000, ea:16'h8003, eb:16'h8003};
    vecs[7] = '{a:3'd1, b:3'd2, sh:2'b01, as:1'b0, bs:1'b1, im:5'b01111, ea:16'h0005, eb:16'h000F};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ain", {16'd0, Ain}, 32'd0);
    chk("rst_bin", {16'd0, Bin}, 32'd0);

    do_write(3'd1, 16'h0005);
    do_write(3'd2, 16'h8003);
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].as, vecs[i].bs, vecs[i].im,
            0, 1'b0, 3'd0, 16'h0, ga, gb);
      chk($sformatf("vec%0d_ain", i), {16'd0, ga}, {16'd0, vecs[i].ea});
      chk($sformatf("vec%0d_bin", i), {16'd0, gb}, {16'd0, vecs[i].eb});
    end

    // Backpressure: hold 5 cycles with a competing request that must be ignored.
    issue(3'd2, 3'd1, 2'b11, 1'b0, 1'b0, 5'd0, 5, 1'b0, 3'd0, 16'h0, ga, gb);
    chk("bp_ain", {16'd0, ga}, 32'h8003);
    chk("bp_bin", {16'd0, gb}, 32'h0002);

    // Write to R3 during the cycle that reads it as A.
    issue(3'd3, 3'd3, 2'b00, 1'b0, 1'b0, 5'd0, 0, 1'b1, 3'd3, 16'h1234, ga, gb);
    mem[3] = 32'h1234;
`ifdef OPERAND_FWD_EN
    chk("fwd_ain", {16'd0, ga}, 32'h1234);
`else
    chk("nofwd_ain", {16'd0, ga}, 32'h0000);
`endif
    chk("fwd_bin", {16'd0, gb}, 32'h1234);
    issue(3'd3, 3'd0, 2'b00, 1'b0, 1'b0, 5'd0, 0, 1'b0, 3'd0, 16'h0, ga, gb);
    chk("second_read_r3", {16'd0, ga}, 32'h1234);

    // Reset while in RD_B, with a write in the reset cycle that must be dropped.
    @(negedge clk);
    req_valid = 1'b1; readnum_a = 3'd1; readnum_b = 3'd2; shift = 2'b00;
    asel = 1'b0; bsel = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1; write = 1'b1; writenum = 3'd4; data_in = 16'hBEEF;
    @(negedge clk);
    reset = 1'b0; write = 1'b0;
    chk("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid_ain", {16'd0, Ain}, 32'd0);
    chk("rstmid_bin", {16'd0, Bin}, 32'd0);
    for (int i = 0; i < 8; i++) mem[i] = 0;
    for (int i = 0; i < 8; i += 2) begin
      issue(3'(i), 3'(i + 1), 2'b00, 1'b0, 1'b0, 5'd0, 0, 1'b0, 3'd0, 16'h0, ga, gb);
      chk($sformatf("cleared_r%0d", i), {16'd0, ga}, 32'd0);
      chk($sformatf("cleared_r%0d", i + 1), {16'd0, gb}, 32'd0);
    end

    // Random requests against the reference model.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) do_write(3'($urandom), 16'($urandom));
      ra = 3'($urandom); rb = 3'($urandom); sh = 2'($urandom);
      as = ($urandom_range(0, 3) == 0); bs = ($urandom_range(0, 3) == 0);
      im = 5'($urandom);
      issue(ra, rb, sh, as, bs, im, $urandom_range(0, 3), 1'b0, 3'd0, 16'h0, ga, gb);
      chk($sformatf("rand%0d_ain", n), {16'd0, ga}, as ? 32'd0 : 32'(mem[ra]));
      chk($sformatf("rand%0d_bin", n), {16'd0, gb},
          {16'd0, model_b(mem[rb], int'(sh), int'(bs), int'(im))});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
